// File: rtl/frame_max_finder.sv
// Purpose : per-frame running maximum (first occurrence), its index, sample count and overflow flag.
// Latency : result valid the cycle after the accept carrying in_last.
// Backpr. : in_ready drops while a result is held; the result stays stable until out_valid && out_ready.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last - sample stream, in_last marks the frame's final sample
//   out_valid/out_ready               - result handshake
//   out_max/out_max_idx/out_count/out_overflow - registered frame result
module frame_max_finder #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [CNT_WIDTH-1:0]  out_max_idx,
    output logic [CNT_WIDTH:0]    out_count,
    output logic                  out_overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // Saturation point of the counter: 2^CNT_WIDTH.
    localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b1, {CNT_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH:0] CNT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    typedef struct packed {
        logic [DATA_WIDTH-1:0] max;
        logic [CNT_WIDTH-1:0]  idx;
        logic [CNT_WIDTH:0]    cnt;
        logic                  ovf;
    } result_t;

    localparam result_t RESULT_ZERO = '0;

    logic [1:0] r_state;
    logic       r_in_ready;
    logic       r_out_valid;
    result_t    r_acc;      // running accumulators for the frame in progress
    result_t    r_res;      // last completed result, drives the outputs
    result_t    w_acc_nxt;  // accumulator value if the current sample is accepted
    logic       w_accept;
    logic       w_transfer;

    assign w_accept   = in_valid && r_in_ready;
    assign w_transfer = r_out_valid && out_ready;

    // Next accumulator contents assuming an accept this cycle.
    always_comb begin
        w_acc_nxt = r_acc;
        if (r_state == S_IDLE) begin
            w_acc_nxt.max = in_data;
            w_acc_nxt.idx = '0;
            w_acc_nxt.cnt = CNT_ONE;
            w_acc_nxt.ovf = 1'b0;
        end else if (r_acc.cnt == CNT_MAX) begin
            // Frame too long: sample is swallowed without comparison.
            w_acc_nxt.ovf = 1'b1;
        end else begin
            // Strict compare so ties keep the first occurrence.
            if (in_data > r_acc.max) begin
                w_acc_nxt.max = in_data;
                w_acc_nxt.idx = r_acc.cnt[CNT_WIDTH-1:0];
            end
            w_acc_nxt.cnt = r_acc.cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= RESULT_ZERO;
            r_res       <= RESULT_ZERO;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        if (in_last) begin
                            r_state     <= S_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_res       <= w_acc_nxt;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_transfer) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_max      = r_res.max;
    assign out_max_idx  = r_res.idx;
    assign out_count    = r_res.cnt;
    assign out_overflow = r_res.ovf;

endmodule

// File: doc/frame_max_finder.md
Name: frame_max_finder

Overview:
- Sequential stage directly downstream of the 4-bit greater comparator. It consumes a framed stream of unsigned samples and uses an a > b comparison against a running maximum.
- For each frame it reports the maximum value, the index of its first occurrence, and the sample count.
- Output is a single registered result word, transferred under a valid/ready handshake.

Parameters:
- DATA_WIDTH, 4, sample width (unsigned).
- CNT_WIDTH, 4, index width. A frame holds at most 2^CNT_WIDTH samples (16 by default).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  DATA_WIDTH  sample.
- in_last  input  1  marks the final sample of a frame.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result.
- out_max  output  DATA_WIDTH  maximum of the frame.
- out_max_idx  output  CNT_WIDTH  0-based index of the first occurrence of the maximum.
- out_count  output  CNT_WIDTH+1  number of samples compared (1..2^CNT_WIDTH).
- out_overflow  output  1  frame exceeded 2^CNT_WIDTH samples.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset (sampled at a clk edge) forces:
  - state=IDLE, in_ready=1, out_valid=0;
  - out_max=0, out_max_idx=0, out_count=0, out_overflow=0;
  - all internal accumulators cleared.
- Reset mid-frame or while a result is held discards the frame/result; no output handshake occurs.
- Accept event: in_valid && in_ready at a clk edge. Result transfer: out_valid && out_ready at a clk edge.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept: max<=in_data, idx<=0, cnt<=1, ovf<=0.
  - in_last=1 -> HOLD; else -> ACCUM.
- ACCUM (in_ready=1, out_valid=0), on accept:
  - If cnt < 2^CNT_WIDTH: when in_data > max (strict, unsigned), max<=in_data and idx<=cnt[CNT_WIDTH-1:0]. Then cnt<=cnt+1.
  - If cnt == 2^CNT_WIDTH: sample is accepted but discarded (no compare); cnt holds; ovf<=1 (sticky for the frame).
  - in_last=1 -> HOLD.
  - No accept -> stay in ACCUM; accumulators hold.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_max/out_max_idx/out_count/out_overflow are driven from registers and stay stable until transfer.
  - On transfer -> IDLE; out_valid deasserts the next cycle.
- Outputs outside HOLD keep the last transferred result (0 after reset). They are meaningful only while out_valid=1.
- Latency: out_valid rises the cycle after the accept carrying in_last. A 1-sample frame therefore yields a result one cycle after its accept.
- Minimum frame-to-frame spacing: after a transfer, the next frame's first sample can be accepted in the next cycle (the block is back in IDLE). There is no overlap of input and output.
- Ties: equal values never replace the maximum, so the first occurrence wins.
- Width rules:
  - cnt is CNT_WIDTH+1 bits and saturates at 2^CNT_WIDTH.
  - idx is always < 2^CNT_WIDTH.
  - The comparison is purely unsigned across DATA_WIDTH bits.
- in_valid=0 leaves in_data/in_last ignored. out_ready is ignored outside HOLD.
- in_ready is a registered function of state only; it does not depend combinationally on in_valid.

Test Plan:
- Reset then frame 3,9,2,9,5 (last on 5), out_ready=1 -> one cycle after the last accept: out_valid=1, out_max=9, out_max_idx=1, out_count=5, out_overflow=0; out_valid=0 the following cycle.
- Single-sample frame 0 with in_last=1 -> out_max=0, out_max_idx=0, out_count=1. Then frame 15,15 -> out_max=15, out_max_idx=0, out_count=2.
- Backpressure: hold out_ready=0 for 4 cycles in HOLD while in_valid=1 -> in_ready=0, no samples consumed, outputs stable; transfer occurs on the cycle out_ready=1.
- Overflow: 18-sample frame with values 1..15,0,15,14 (last on 14) -> out_count=16, out_overflow=1, out_max=15, out_max_idx=14. The discarded samples (15,14) do not alter max/idx.
- Reset mid-frame after samples 7,12, then frame 4,2 -> no result for the aborted frame; result is out_max=4, out_max_idx=0, out_count=2, out_overflow=0.
- Gapped input: frame 1,8,6 with in_valid deasserted for 2 cycles between samples -> same result as ungapped (max 8, idx 1, count 3); idle cycles do not increment count.
